freq_gate_counter: RTL and testbench

//  Gated frequency meter front end: counts rising edges of an async input over a fixed window of

---
 rtl/freq_gate_counter.sv | 92 +++++++++
 tb/tb_freq_gate_counter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/freq_gate_counter.sv
// freq_gate_counter: gated frequency meter counting sig_in rising edges per GATE_CYCLES window in packed BCD
// clk_in/resetn_in: single clock, synchronous active-low reset
// sig_in: asynchronous input under measurement; ready_in: consumer accepts a refresh strobe
// digits_out/overflow_out: last completed window result; refresh_stb_out: new-result pulse; gate_out: toggles per window
module freq_gate_counter #(
  parameter int DIGITS_NUM  = 6,
  parameter int GATE_CYCLES = 20000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk_in,
  input  logic                    resetn_in,
  input  logic                    sig_in,
  input  logic                    ready_in,
  output logic [4*DIGITS_NUM-1:0] digits_out,
  output logic                    overflow_out,
  output logic                    refresh_stb_out,
  output logic                    gate_out
);
  localparam int GW = $clog2(GATE_CYCLES);
  localparam int AW = $clog2(SYNC_STAGES + 2);
  localparam int BW = 4 * DIGITS_NUM;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [AW-1:0]          arm_q, arm_d;
  logic [GW-1:0]          gate_q, gate_d;
  logic [BW-1:0]          acc_q, acc_d, digits_q, digits_d, inc, cnt;
  logic                   ovf_q, ovf_d, ovfo_q, ovfo_d, pend_q, pend_d, stb_q, stb_d, tog_q, tog_d;
  logic                   armed, sig_edge, win_end, carry, all9, ovf_cnt;
  logic [3:0]             d4;
  always_comb begin
    // until the chain and prev flop hold post-reset samples, a high input would look like an edge
    armed    = arm_q == AW'(SYNC_STAGES + 1);
    arm_d    = armed ? arm_q : arm_q + 1'b1;
    sync_d   = {sync_q[SYNC_STAGES-2:0], sig_in};
    prev_d   = sync_q[SYNC_STAGES-1];
    sig_edge = armed & sync_q[SYNC_STAGES-1] & ~prev_q;
    win_end  = gate_q == GW'(GATE_CYCLES - 1);
    gate_d   = win_end ? '0 : gate_q + 1'b1;
    carry    = 1'b1;
    all9     = 1'b1;
    d4       = '0;
    inc      = acc_q;
    for (int i = 0; i < DIGITS_NUM; i++) begin
      d4                = acc_q[4*i +: 4];
      inc[4*i +: 4]     = carry ? ((d4 == 4'd9) ? 4'd0 : d4 + 4'd1) : d4;
      all9              = all9 & (d4 == 4'd9);
      carry             = carry & (d4 == 4'd9);
    end
    // saturate at all nines instead of wrapping to zero
    cnt      = (sig_edge && !all9) ? inc : acc_q;
    ovf_cnt  = ovf_q | (sig_edge & all9);
    acc_d    = win_end ? '0 : cnt;
    ovf_d    = win_end ? 1'b0 : ovf_cnt;
    digits_d = win_end ? cnt : digits_q;
    ovfo_d   = win_end ? ovf_cnt : ovfo_q;
    tog_d    = tog_q ^ win_end;
    stb_d    = pend_q & ready_in;
    // a window end on the strobe-issue edge keeps pending so the new result gets its own strobe
    pend_d   = win_end | (pend_q & ~ready_in);
  end
  always_ff @(posedge clk_in) begin
    if (!resetn_in) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      arm_q    <= '0;
      gate_q   <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      digits_q <= '0;
      ovfo_q   <= 1'b0;
      pend_q   <= 1'b0;
      stb_q    <= 1'b0;
      tog_q    <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      arm_q    <= arm_d;
      gate_q   <= gate_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      digits_q <= digits_d;
      ovfo_q   <= ovfo_d;
      pend_q   <= pend_d;
      stb_q    <= stb_d;
      tog_q    <= tog_d;
    end
  end
  assign digits_out      = digits_q;
  assign overflow_out    = ovfo_q;
  assign refresh_stb_out = stb_q;
  assign gate_out        = tog_q;
endmodule

// File: tb/tb_freq_gate_counter.sv
// tb_freq_gate_counter: window-by-window stimulus table with a strobe scoreboard for freq_gate_counter
module tb_freq_gate_counter;
  localparam int NONE = 1000;
  typedef struct {
    bit          rel;
    int          p;
    int          kind;
    int          rdy_u;
    int          rst_u;
    int          nstb;
    logic [23:0] dig;
    bit          ovf;
  } vec_t;
  typedef struct {
    logic [23:0] dig;
    bit          ovf;
  } res_t;
  logic        clk = 1'b0;
  logic        resetn_a = 1'b0, resetn_b = 1'b0, sig = 1'b0, ready = 1'b0, sel = 1'b0;
  logic [23:0] dig_a, dig;
  logic [7:0]  dig_b;
  logic        ovf_a, ovf_b, stb_a, stb_b, gate_a, gate_b, ovf, stb, gate;
  int          checks = 0, fails = 0, G = 100, nwin = 0;
  bit          have_prev = 1'b0, have_last = 1'b0;
  logic [23:0] prev_dig = '0;
  bit          prev_ovf = 1'b0;
  res_t        q[$];
  res_t        last;
  vec_t        tab_a[16];
  vec_t        tab_b[4];
  always #5 clk = ~clk;
  freq_gate_counter #(.DIGITS_NUM(6), .GATE_CYCLES(100), .SYNC_STAGES(2)) dut_a (
    .clk_in(clk), .resetn_in(resetn_a), .sig_in(sig), .ready_in(ready),
    .digits_out(dig_a), .overflow_out(ovf_a), .refresh_stb_out(stb_a), .gate_out(gate_a)
  );
  freq_gate_counter #(.DIGITS_NUM(2), .GATE_CYCLES(400), .SYNC_STAGES(2)) dut_b (
    .clk_in(clk), .resetn_in(resetn_b), .sig_in(sig), .ready_in(ready),
    .digits_out(dig_b), .overflow_out(ovf_b), .refresh_stb_out(stb_b), .gate_out(gate_b)
  );
  assign dig  = sel ? {16'h0, dig_b} : dig_a;
  assign ovf  = sel ? ovf_b : ovf_a;
  assign stb  = sel ? stb_b : stb_a;
  assign gate = sel ? gate_b : gate_a;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (stb) begin
      if (q.size() > 0) begin
        last      = q[q.size()-1];
        have_last = 1'b1;
        q.delete();
      end
      chk("stb_has_data", {31'd0, have_last}, 1);
      chk("stb_digits", dig, last.dig);
      chk("stb_ovf", {31'd0, ovf}, {31'd0, last.ovf});
    end
  end
  task automatic set_rst(input logic v);
    if (sel) resetn_b = v;
    else resetn_a = v;
  endtask
  // driver window: iteration u runs two cycles ahead of DUT gate cycle u, so an input rise at u counts at gate cycle u
  task automatic run_window(input vec_t v);
    int n = 0;
    bit s;
    for (int u = 0; u < G; u++) begin
      @(negedge clk);
      if (stb) n++;
      if (u == 2) begin
        chk("digits_at_update", dig, prev_dig);
        chk("ovf_at_update", {31'd0, ovf}, {31'd0, prev_ovf});
        chk("gate_parity", {31'd0, gate}, nwin & 1);
        if (v.rdy_u != 1) chk("stb_not_early", {31'd0, stb}, 0);
      end
      if (u == 3) chk("stb_timing", {31'd0, stb}, {31'd0, have_prev && v.rdy_u <= 2});
      if (u == 60 && v.rst_u < 60) begin
        chk("rst_mid_digits", dig, 0);
        chk("rst_mid_ovf", {31'd0, ovf}, 0);
        chk("rst_mid_stb", {31'd0, stb}, 0);
        chk("rst_mid_gate", {31'd0, gate}, 0);
      end
      s = (u % v.p) >= v.p / 2;
      if (v.kind == 1 && u == 0) s = 1'b1;
      if (v.kind == 1 && u == 1) s = 1'b0;
      if (v.kind == 2 && u == G - 1) s = 1'b0;
      if (v.kind == 3 && u == G - 2) s = 1'b0;
      if (v.kind == 3 && u == G - 1) s = 1'b1;
      sig   = s;
      ready = u >= v.rdy_u;
      if (v.rel && u == 2) set_rst(1'b1);
      if (u == v.rst_u) set_rst(1'b0);
    end
    chk("strobe_count", n, v.nstb);
    if (v.rst_u < G) begin
      have_prev = 1'b0;
      prev_dig  = '0;
      prev_ovf  = 1'b0;
      nwin      = 0;
      have_last = 1'b0;
      q.delete();
    end else begin
      q.push_back('{v.dig, v.ovf});
      prev_dig  = v.dig;
      prev_ovf  = v.ovf;
      have_prev = 1'b1;
      nwin++;
    end
  endtask
  initial begin
    tab_a[0]  = '{1, 10, 0, 0,    NONE, 0, 24'h10, 0};
    tab_a[1]  = '{0, 4,  0, 0,    NONE, 1, 24'h25, 0};
    tab_a[2]  = '{0, 4,  0, 0,    NONE, 1, 24'h25, 0};
    tab_a[3]  = '{0, 4,  2, 0,    NONE, 1, 24'h25, 0};
    tab_a[4]  = '{0, 4,  1, 0,    NONE, 1, 24'h26, 0};
    tab_a[5]  = '{0, 4,  3, 0,    NONE, 1, 24'h25, 0};
    tab_a[6]  = '{0, 4,  0, 0,    NONE, 1, 24'h25, 0};
    tab_a[7]  = '{0, 10, 0, NONE, NONE, 0, 24'h10, 0};
    tab_a[8]  = '{0, 4,  0, 50,   NONE, 1, 24'h25, 0};
    tab_a[9]  = '{0, 4,  0, 0,    NONE, 1, 24'h25, 0};
    tab_a[10] = '{0, 4,  0, NONE, NONE, 0, 24'h25, 0};
    tab_a[11] = '{0, 10, 0, 1,    NONE, 2, 24'h10, 0};
    tab_a[12] = '{0, 4,  0, 0,    NONE, 1, 24'h25, 0};
    tab_a[13] = '{0, 4,  0, 0,    52,   1, 24'h25, 0};
    tab_a[14] = '{1, 10, 0, 0,    NONE, 0, 24'h10, 0};
    tab_a[15] = '{0, 4,  0, 0,    NONE, 1, 24'h25, 0};
    tab_b[0]  = '{1, 8,  0, 0,    NONE, 0, 24'h50, 0};
    tab_b[1]  = '{0, 2,  0, 0,    NONE, 1, 24'h99, 1};
    tab_b[2]  = '{0, 8,  0, 0,    NONE, 1, 24'h50, 0};
    tab_b[3]  = '{0, 8,  0, 0,    NONE, 1, 24'h50, 0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("reset_digits", dig_a, 0);
      chk("reset_ovf", {31'd0, ovf_a}, 0);
      chk("reset_stb", {31'd0, stb_a}, 0);
      chk("reset_gate", {31'd0, gate_a}, 0);
      sig = ~sig;
    end
    sig = 1'b0;
    for (int i = 0; i < 16; i++) run_window(tab_a[i]);
    sel       = 1'b1;
    G         = 400;
    have_prev = 1'b0;
    prev_dig  = '0;
    prev_ovf  = 1'b0;
    nwin      = 0;
    have_last = 1'b0;
    q.delete();
    run_window(tab_b[0]);
    run_window(tab_b[1]);
    run_window(tab_b[2]);
    run_window(tab_b[3]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
